// File: rtl/spoly_sampler_ctrl.sv
// spoly_sampler_ctrl
//
// Builds a fixed-weight ternary polynomial in an external coefficient RAM.
// A run first zeroes addresses 0..P-1. It then takes 13-bit random words and
// places exactly W nonzero coefficients (+1 or Q-1) at distinct positions.
// A word is rejected when its index is out of range or its slot is already
// occupied. The block owns the memory port for the whole run.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      run request, sampled only while idle
//   busy       high whenever a run is in progress (any state but IDLE)
//   done       one-cycle pulse when the run completes
//   rand_data  random word: [9:0] candidate index, [10] sign (1 = -1)
//   rand_valid rand_data valid
//   rand_ready high only while waiting for a word
//   mem_addr   RAM address (index zero-extended)
//   mem_wdata  RAM write data: 0, 1 or Q-1
//   mem_we     RAM write strobe
//   mem_rdata  RAM read data, one cycle after the address is sampled
//   count      nonzero coefficients placed so far
//   rejects    rejected words this run, saturating at 0xFFFF
module spoly_sampler_ctrl #(
    parameter int P = 677,
    parameter int W = 250,
    parameter int Q = 4621
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [12:0] rand_data,
    input  logic        rand_valid,
    output logic        rand_ready,
    output logic [10:0] mem_addr,
    output logic [12:0] mem_wdata,
    output logic        mem_we,
    input  logic [12:0] mem_rdata,
    output logic [10:0] count,
    output logic [15:0] rejects
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_DRAW  = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [10:0] LAST_ADDR = 11'(P - 1);
    localparam logic [10:0] P_LIM     = 11'(P);
    localparam logic [10:0] W_LIM     = 11'(W);
    localparam logic [12:0] NEG_ONE   = 13'(Q - 1);

    logic [2:0]  state_reg, state_next;
    logic        sign_reg, sign_next;
    logic [10:0] mem_addr_reg, mem_addr_next;
    logic [12:0] mem_wdata_reg, mem_wdata_next;
    logic        mem_we_reg, mem_we_next;
    logic [10:0] count_reg, count_next;
    logic [15:0] rejects_reg, rejects_next;
    logic [15:0] rejects_inc;
    logic [10:0] cand_index;

    // The top two bits of the random word carry no meaning here.
    logic [1:0]  unused_rand_bits;
    assign unused_rand_bits = rand_data[12:11];

    assign cand_index  = {1'b0, rand_data[9:0]};
    assign rejects_inc = (rejects_reg == 16'hFFFF) ? rejects_reg : rejects_reg + 16'd1;

    always_comb begin
        state_next     = state_reg;
        sign_next      = sign_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = 13'd0;
        mem_we_next    = 1'b0;
        count_next     = count_reg;
        rejects_next   = rejects_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_CLEAR;
                    count_next    = 11'd0;
                    rejects_next  = 16'd0;
                    mem_addr_next = 11'd0;
                    mem_we_next   = 1'b1;
                end
            end
            S_CLEAR: begin
                // mem_addr doubles as the clear pointer.
                if (mem_addr_reg == LAST_ADDR) begin
                    state_next = S_DRAW;
                end else begin
                    mem_addr_next = mem_addr_reg + 11'd1;
                    mem_we_next   = 1'b1;
                end
            end
            S_DRAW: begin
                // rand_ready is high in this state, so rand_valid alone
                // marks a handshake.
                if (rand_valid) begin
                    if (cand_index >= P_LIM) begin
                        rejects_next = rejects_inc;
                    end else begin
                        mem_addr_next = cand_index;
                        sign_next     = rand_data[10];
                        state_next    = S_READ;
                    end
                end
            end
            S_READ: begin
                state_next = S_CHECK;
            end
            S_CHECK: begin
                // Read data for the address presented in READ is valid now.
                if (mem_rdata != 13'd0) begin
                    rejects_next = rejects_inc;
                    state_next   = S_DRAW;
                end else begin
                    mem_we_next    = 1'b1;
                    mem_wdata_next = sign_reg ? NEG_ONE : 13'd1;
                    count_next     = count_reg + 11'd1;
                    state_next     = S_WRITE;
                end
            end
            S_WRITE: begin
                // count already includes the coefficient being written.
                state_next = (count_reg == W_LIM) ? S_DONE : S_DRAW;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            sign_reg      <= 1'b0;
            mem_addr_reg  <= 11'd0;
            mem_wdata_reg <= 13'd0;
            mem_we_reg    <= 1'b0;
            count_reg     <= 11'd0;
            rejects_reg   <= 16'd0;
        end else begin
            state_reg     <= state_next;
            sign_reg      <= sign_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_we_reg    <= mem_we_next;
            count_reg     <= count_next;
            rejects_reg   <= rejects_next;
        end
    end

    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign rand_ready = (state_reg == S_DRAW);
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_we     = mem_we_reg;
    assign count      = count_reg;
    assign rejects    = rejects_reg;

endmodule

// File: tb/tb_spoly_sampler_ctrl.sv
// Testbench for spoly_sampler_ctrl (P=8, W=3, Q=4621).
// A reference model derives, from each random-word stream, the full list of
// expected RAM writes and the done event (cycle, count, rejects). These are
// queued; a monitor pops and compares them whenever the DUT writes or
// signals done.
module tb_spoly_sampler_ctrl;

    localparam int TP = 8;
    localparam int TW = 3;
    localparam int TQ = 4621;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [12:0] rand_data = 13'd0;
    logic        rand_valid = 1'b0;
    logic        rand_ready;
    logic [10:0] mem_addr;
    logic [12:0] mem_wdata;
    logic        mem_we;
    logic [12:0] mem_rdata = 13'd0;
    logic [10:0] count;
    logic [15:0] rejects;

    spoly_sampler_ctrl #(.P(TP), .W(TW), .Q(TQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rand_data  (rand_data),
        .rand_valid (rand_valid),
        .rand_ready (rand_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .count      (count),
        .rejects    (rejects)
    );

    always #5 clk = ~clk;

    // Coefficient RAM with registered read.
    logic [12:0] ram [0:2047];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int t0 = 0;
    int done_cnt = 0;
    int last_done_rel = 0;

    typedef struct {
        bit is_done;
        int addr;
        int data;
        int cyc;
        int cnt;
        int rej;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int exp_ram [TP];
    logic [12:0] sw[$];
    int sg[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe and done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: addr=%0d data=%0d", mem_addr, mem_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    check("write_addr", int'(mem_addr), mon_e.addr);
                    check("write_data", int'(mem_wdata), mon_e.data);
                end
            end
            if (done) begin
                done_cnt++;
                last_done_rel = cyc - t0;
                if (sb.size() == 0 || !sb[0].is_done) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: cycle=%0d pending=%0d", cyc - t0, sb.size());
                end else begin
                    mon_e = sb.pop_front();
                    check("done_cycle", cyc - t0, mon_e.cyc);
                    check("done_count", int'(count), mon_e.cnt);
                    check("done_rejects", int'(rejects), mon_e.rej);
                end
            end
        end
    end

    task automatic add_word(input logic [12:0] w, input int g);
        sw.push_back(w);
        sg.push_back(g);
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference model: walks the word stream with an occupancy table and
    // accumulates cycle cost. A word followed by a gap of g idle cycles
    // cannot be followed by the next accept sooner than g+1 cycles later.
    task automatic build_model();
        bit occ [TP];
        int placed = 0;
        int rej = 0;
        int cost = TP + 1;
        exp_t e;
        for (int a = 0; a < TP; a++) begin
            occ[a] = 1'b0;
            exp_ram[a] = 0;
            e = '{is_done: 1'b0, addr: a, data: 0, cyc: 0, cnt: 0, rej: 0};
            sb.push_back(e);
        end
        for (int i = 0; i < sw.size(); i++) begin
            int idx = int'(sw[i][9:0]);
            int g = sg[i];
            if (idx >= TP) begin
                rej++;
                cost += imax(1, g + 1);
            end else if (occ[idx]) begin
                rej++;
                cost += imax(3, g + 1);
            end else begin
                occ[idx] = 1'b1;
                exp_ram[idx] = sw[i][10] ? TQ - 1 : 1;
                e = '{is_done: 1'b0, addr: idx, data: exp_ram[idx], cyc: 0, cnt: 0, rej: 0};
                sb.push_back(e);
                placed++;
                if (placed == TW) begin
                    cost += 4;
                    break;
                end
                cost += imax(4, g + 1);
            end
        end
        e = '{is_done: 1'b1, addr: 0, data: 0, cyc: cost, cnt: TW, rej: rej};
        sb.push_back(e);
    endtask

    // Runs the current stream. pa/pb: extra start pulses (relative cycle),
    // abort_at: relative cycle in which rst is asserted (-1 = none).
    task automatic run(input string tag, input int abort_at, input int pa, input int pb);
        int ptr = 0;
        int gapleft = 0;
        int gapchk = 0;
        int rel;
        int dstart;
        bit hs;
        bit fin = 1'b0;
        build_model();
        dstart = done_cnt;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b1;
        rand_valid = 1'b1;
        rand_data = sw[0];
        for (int n = 0; n < 600 && !fin; n++) begin
            @(negedge clk);
            hs = rand_valid && rand_ready;
            if (gapchk > 0) begin
                check("stall_ready", int'(rand_ready), 1);
                gapchk--;
            end
            @(posedge clk); #1;
            rel = cyc - t0;
            start = (rel == pa || rel == pb);
            if (hs) begin
                gapleft = sg[ptr];
                if (int'(sw[ptr][9:0]) >= TP) gapchk = sg[ptr];
                ptr++;
            end
            if (gapleft > 0) begin
                rand_valid = 1'b0;
                gapleft--;
            end else if (ptr < sw.size()) begin
                rand_valid = 1'b1;
                rand_data = sw[ptr];
            end else begin
                rand_valid = 1'b0;
            end
            if (rel == abort_at) begin
                check("pre_abort_we", int'(mem_we), 1);
                check("pre_abort_busy", int'(busy), 1);
                rst = 1'b1;
                #1;
                check("abort_busy", int'(busy), 0);
                check("abort_we", int'(mem_we), 0);
                check("abort_count", int'(count), 0);
                check("abort_ready", int'(rand_ready), 0);
                check("abort_addr", int'(mem_addr), 0);
                sb.delete();
                @(negedge clk);
                rst = 1'b0;
                fin = 1'b1;
            end
            if (done_cnt != dstart) fin = 1'b1;
        end
        start = 1'b0;
        rand_valid = 1'b0;
        if (abort_at < 0) begin
            repeat (4) @(posedge clk);
            #1;
            check({tag, "_done_pulses"}, done_cnt - dstart, 1);
            check({tag, "_idle_busy"}, int'(busy), 0);
            check({tag, "_hold_count"}, int'(count), TW);
            check({tag, "_sb_empty"}, sb.size(), 0);
            for (int a = 0; a < TP; a++) check({tag, "_ram"}, int'(ram[a]), exp_ram[a]);
            $display("run %s: done at cycle %0d count=%0d rejects=%0d", tag,
                     last_done_rel, count, rejects);
        end else begin
            $display("run %s: aborted at cycle %0d", tag, abort_at);
        end
        sb.delete();
    endtask

    task automatic clear_stream();
        sw.delete();
        sg.delete();
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL global_timeout: time=%0t limit=2000000", $time);
        $fatal(1);
    end

    initial begin
        int d_nogap;
        int d_gap;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(rand_ready), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        check("rst_count", int'(count), 0);
        check("rst_rejects", int'(rejects), 0);
        rst = 1'b0;

        // Basic placement, no rejects: done in cycle 21.
        clear_stream();
        add_word(13'h002, 0); add_word(13'h405, 0); add_word(13'h007, 0);
        run("basic", -1, -1, -1);
        check("basic_done_cycle", last_done_rel, 21);

        // Out-of-range and collision rejects.
        clear_stream();
        add_word(13'h00A, 0); add_word(13'h003, 0); add_word(13'h003, 0);
        add_word(13'h004, 0); add_word(13'h000, 0);
        run("rejects", -1, -1, -1);

        // Boundary indices: P (rejected), P-1 and 0 (legal).
        clear_stream();
        add_word(13'h008, 0); add_word(13'h007, 0); add_word(13'h400, 0);
        add_word(13'h1FF, 0); add_word(13'h401, 0);
        run("bounds", -1, -1, -1);

        // Same stream with and without a 5-cycle valid gap inside DRAW.
        clear_stream();
        add_word(13'h3FF, 0); add_word(13'h002, 0); add_word(13'h405, 0); add_word(13'h007, 0);
        run("nogap", -1, -1, -1);
        d_nogap = last_done_rel;
        sg[0] = 5;
        run("gap", -1, -1, -1);
        d_gap = last_done_rel;
        check("gap_delay", d_gap - d_nogap, 5);

        // Extra start pulses during CLEAR and DRAW are ignored.
        run("restart", -1, 3, 11);

        // Reset in cycle 12, then a normal run.
        clear_stream();
        add_word(13'h002, 0); add_word(13'h405, 0); add_word(13'h007, 0);
        run("abort", 12, -1, -1);
        run("after_abort", -1, -1, -1);

        // Randomized streams with gaps; a tail of all indices guarantees completion.
        for (int r = 0; r < 20; r++) begin
            clear_stream();
            for (int i = 0; i < 12; i++) begin
                logic [12:0] w;
                w = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15))};
                add_word(w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
            end
            for (int a = 0; a < TP; a++) add_word(13'(a) | 13'($urandom_range(0, 1) << 10), 0);
            run("random", -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
